// File: rtl/fir_filter_mc.sv
// Multi-channel time-multiplexed FIR: one signed MAC shared across NUM_CH channels and TAPS taps,
// runtime-writable shared coefficient bank, round-half-up + saturate, valid/ready input, bypass.
module fir_filter_mc #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned COEF_FRAC = 14,
  parameter int unsigned TAPS      = 16,
  parameter int unsigned NUM_CH    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic                       out_valid,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  input  logic                       bypass,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  output logic                       busy
);

  localparam int unsigned TAP_W   = $clog2(TAPS);
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PROD_W  = DATA_W + COEF_W;
  localparam int unsigned ACC_W   = PROD_W + TAP_W;
  localparam int unsigned FRAME_W = NUM_CH * DATA_W;
  localparam int unsigned HI_W    = ACC_W - DATA_W + 1;

  localparam logic [ACC_W-1:0]  HALF    = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, MAC, ROUND, OUT} state_t;

  state_t                    state, state_nxt;
  logic signed [DATA_W-1:0]  x    [NUM_CH][TAPS];
  logic signed [COEF_W-1:0]  coef [TAPS];
  logic [FRAME_W-1:0]        frame_q;
  logic [FRAME_W-1:0]        res_q;
  logic signed [ACC_W-1:0]   acc;
  logic [TAP_W-1:0]          tap;
  logic [CH_W-1:0]           ch;

  logic                      hs_c;
  logic                      coef_wr_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [ACC_W-1:0]   rnd_c;
  logic signed [ACC_W-1:0]   shf_c;
  logic [HI_W-1:0]           hi_c;
  logic [DATA_W-1:0]         sat_c;
  logic [FRAME_W-1:0]        res_c;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake/write qualification, MAC product and round/saturate path
  always_comb begin
    state_nxt = state;
    hs_c      = 1'b0;
    coef_wr_c = 1'b0;
    prod_c    = x[ch][tap] * coef[tap];
    rnd_c     = acc + $signed(HALF);
    shf_c     = rnd_c >>> COEF_FRAC;
    hi_c      = shf_c[ACC_W-1:DATA_W-1];
    sat_c     = ((&hi_c) || !(|hi_c)) ? shf_c[DATA_W-1:0]
                                      : (shf_c[ACC_W-1] ? SAT_MIN : SAT_MAX);
    res_c     = res_q;
    case (state)
      IDLE: begin
        hs_c      = in_valid;
        coef_wr_c = coef_we && !in_valid;
        if (in_valid) state_nxt = bypass ? OUT : LOAD;
      end
      LOAD:  state_nxt = MAC;
      MAC:   if (tap == TAP_W'(TAPS - 1)) state_nxt = ROUND;
      ROUND: begin
        res_c[ch*DATA_W +: DATA_W] = sat_c;
        state_nxt = (ch == CH_W'(NUM_CH - 1)) ? OUT : MAC;
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: coefficient bank, delay lines, accumulator, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(TAPS); k++) coef[k] <= '0;
      coef[0] <= COEF_W'(1) << COEF_FRAC;
      for (int c = 0; c < int'(NUM_CH); c++)
        for (int k = 0; k < int'(TAPS); k++) x[c][k] <= '0;
      frame_q   <= '0;
      res_q     <= '0;
      acc       <= '0;
      tap       <= '0;
      ch        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      if (coef_wr_c) coef[coef_addr] <= coef_data;
      case (state)
        IDLE: if (hs_c) frame_q <= in_data;
        LOAD: begin
          for (int c = 0; c < int'(NUM_CH); c++) begin
            x[c][0] <= frame_q[c*DATA_W +: DATA_W];
            for (int k = 1; k < int'(TAPS); k++) x[c][k] <= x[c][k-1];
          end
          acc <= '0;
          tap <= '0;
          ch  <= '0;
        end
        MAC: begin
          acc <= acc + {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
          tap <= (tap == TAP_W'(TAPS - 1)) ? '0 : tap + TAP_W'(1);
        end
        ROUND: begin
          res_q <= res_c;
          if (ch != CH_W'(NUM_CH - 1)) begin
            ch  <= ch + CH_W'(1);
            acc <= '0;
          end
        end
        default: ;
      endcase
      // Bypass frames come straight from the input bus; filtered frames from the rounded slots
      if (state_nxt == OUT) out_data <= (state == IDLE) ? in_data : res_c;
      out_valid <= (state_nxt == OUT);
      in_ready  <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Self-checking bench for fir_filter_mc: scenario tasks compared against a behavioural
// FIR model built from sample-history arrays and plain integer arithmetic.
module tb_fir_filter_mc;

  localparam int TAPS = 16;
  localparam int NCH  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        bypass = 1'b0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int hist [NCH][TAPS];
  int mc   [TAPS];

  fir_filter_mc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .bypass(bypass), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
    for (int k = 0; k < TAPS; k++) mc[k] = 0;
    mc[0] = 16384;
  endfunction

  function automatic void model_push(input int d0, input int d1);
    for (int k = TAPS - 1; k > 0; k--) begin
      hist[0][k] = hist[0][k-1];
      hist[1][k] = hist[1][k-1];
    end
    hist[0][0] = d0;
    hist[1][0] = d1;
  endfunction

  function automatic int model_out(input int c);
    longint acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(hist[c][k]) * longint'(mc[k]);
    acc = (acc + 64'sd8192) >>> 14;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  function automatic int ch_val(input logic [31:0] w, input int c);
    logic signed [15:0] s;
    s = w[c*16 +: 16];
    return int'(s);
  endfunction

  function automatic int rand_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; coef_we = 1'b0; bypass = 1'b0;
    tick(); tick();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    ok = in_ready;
  endtask

  task automatic write_coef(input int addr, input int val);
    bit ok;
    wait_ready(ok);
    coef_we = 1'b1; coef_addr = 4'(addr); coef_data = 16'(val);
    tick();
    coef_we = 1'b0;
    if (ok) mc[addr] = val;
  endtask

  task automatic start_frame(input int d0, input int d1, input bit byp, output bit ok);
    wait_ready(ok);
    in_data = {16'(d1), 16'(d0)};
    bypass = byp; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bypass = ~byp;
    if (ok && !byp) model_push(d0, d1);
  endtask

  task automatic wait_out(output logic [31:0] got, output int lat);
    lat = 1; got = '0;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    if (out_valid) got = out_data;
    else lat = -1;
  endtask

  task automatic run_frame(input int d0, input int d1, input bit byp,
                           output logic [31:0] got, output int lat);
    bit ok;
    start_frame(d0, d1, byp, ok);
    wait_out(got, lat);
    if (!ok) lat = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_identity();
    logic [31:0] got; int lat;
    for (int i = 0; i < 3; i++) begin
      run_frame(1000, -1000, 1'b0, got, lat);
      n_cmp++; if (lat !== 36) begin n_err++; $display("FAIL ident_latency: got %0d expected 36", lat); end
      n_cmp++; if (ch_val(got, 0) !== 1000) begin n_err++; $display("FAIL ident_ch0: got %0d expected 1000", ch_val(got, 0)); end
      n_cmp++; if (ch_val(got, 1) !== -1000) begin n_err++; $display("FAIL ident_ch1: got %0d expected -1000", ch_val(got, 1)); end
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ident_pulse_width: got %b expected 0", out_valid); end
    for (int i = 0; i < 6; i++) begin
      int d0 = rand_s16();
      int d1 = rand_s16();
      run_frame(d0, d1, 1'b0, got, lat);
      n_cmp++;
      if (lat < 0 || ch_val(got, 0) !== model_out(0) || ch_val(got, 1) !== model_out(1)) begin
        n_err++;
        $display("FAIL ident_rand: got %0d/%0d expected %0d/%0d", ch_val(got, 0), ch_val(got, 1), model_out(0), model_out(1));
      end
    end
  endtask

  task automatic test_impulse();
    logic [31:0] got; int lat;
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 100 * (k + 1));
    for (int f = 0; f < TAPS; f++) begin
      run_frame((f == 0) ? 16384 : 0, 0, 1'b0, got, lat);
      n_cmp++;
      if (lat < 0 || ch_val(got, 0) !== 100 * (f + 1)) begin
        n_err++; $display("FAIL impulse_ch0[%0d]: got %0d expected %0d", f, ch_val(got, 0), 100 * (f + 1));
      end
      n_cmp++;
      if (ch_val(got, 1) !== 0) begin
        n_err++; $display("FAIL impulse_ch1[%0d]: got %0d expected 0", f, ch_val(got, 1));
      end
    end
  endtask

  task automatic test_round_sat();
    logic [31:0] got; int lat;
    do_reset();
    write_coef(0, 8192);
    run_frame(3, -3, 1'b0, got, lat);
    n_cmp++; if (lat < 0 || ch_val(got, 0) !== 2) begin n_err++; $display("FAIL round_pos: got %0d expected 2", ch_val(got, 0)); end
    n_cmp++; if (ch_val(got, 1) !== -1) begin n_err++; $display("FAIL round_neg: got %0d expected -1", ch_val(got, 1)); end
    write_coef(0, 32767);
    run_frame(32767, -32768, 1'b0, got, lat);
    n_cmp++; if (lat < 0 || ch_val(got, 0) !== 32767) begin n_err++; $display("FAIL sat_pos: got %0d expected 32767", ch_val(got, 0)); end
    n_cmp++; if (ch_val(got, 1) !== -32768) begin n_err++; $display("FAIL sat_neg: got %0d expected -32768", ch_val(got, 1)); end
  endtask

  task automatic test_random();
    logic [31:0] got; int lat;
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 40000)) - 20000);
    for (int i = 0; i < 20; i++) begin
      int d0 = rand_s16();
      int d1 = rand_s16();
      bit byp = ($urandom_range(0, 4) == 0);
      int e0, e1;
      run_frame(d0, d1, byp, got, lat);
      e0 = byp ? d0 : model_out(0);
      e1 = byp ? d1 : model_out(1);
      n_cmp++;
      if (lat < 0 || ch_val(got, 0) !== e0 || ch_val(got, 1) !== e1) begin
        n_err++; $display("FAIL random[%0d] byp=%0d: got %0d/%0d expected %0d/%0d", i, byp, ch_val(got, 0), ch_val(got, 1), e0, e1);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] got; int lat;
    do_reset();
    write_coef(1, 16384);
    run_frame(100, 200, 1'b0, got, lat);
    n_cmp++; if (lat < 0 || got !== {16'(200), 16'(100)}) begin n_err++; $display("FAIL byp_pre: got %h expected %h", got, {16'(200), 16'(100)}); end
    run_frame(32'h1234, 32'hABCD, 1'b1, got, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL byp_latency: got %0d expected 1", lat); end
    n_cmp++; if (got !== 32'hABCD1234) begin n_err++; $display("FAIL byp_data: got %h expected abcd1234", got); end
    run_frame(10, 20, 1'b0, got, lat);
    n_cmp++; if (lat < 0 || ch_val(got, 0) !== 110) begin n_err++; $display("FAIL byp_delay_ch0: got %0d expected 110", ch_val(got, 0)); end
    n_cmp++; if (ch_val(got, 1) !== 220) begin n_err++; $display("FAIL byp_delay_ch1: got %0d expected 220", ch_val(got, 1)); end
  endtask

  task automatic test_coef_gating();
    logic [31:0] got; int lat; bit ok;
    do_reset();
    start_frame(700, -700, 1'b0, ok);
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL gate_busy: got %b expected 1", busy); end
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'd5000;
    tick(); tick(); tick();
    coef_we = 1'b0;
    wait_out(got, lat);
    n_cmp++; if (lat < 0 || ch_val(got, 0) !== 700) begin n_err++; $display("FAIL gate_busy_frame: got %0d expected 700", ch_val(got, 0)); end
    run_frame(300, -300, 1'b0, got, lat);
    n_cmp++; if (lat < 0 || ch_val(got, 0) !== 300 || ch_val(got, 1) !== -300) begin n_err++; $display("FAIL gate_busy_after: got %0d/%0d expected 300/-300", ch_val(got, 0), ch_val(got, 1)); end
    wait_ready(ok);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'd5000;
    start_frame(400, -400, 1'b0, ok);
    coef_we = 1'b0;
    wait_out(got, lat);
    n_cmp++; if (lat < 0 || ch_val(got, 0) !== 400) begin n_err++; $display("FAIL gate_hs_frame: got %0d expected 400", ch_val(got, 0)); end
    run_frame(250, -250, 1'b0, got, lat);
    n_cmp++; if (lat < 0 || ch_val(got, 0) !== 250 || ch_val(got, 1) !== -250) begin n_err++; $display("FAIL gate_hs_after: got %0d/%0d expected 250/-250", ch_val(got, 0), ch_val(got, 1)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got; int lat; bit ok; int seen = 0;
    do_reset();
    write_coef(0, 8192);
    run_frame(800, 0, 1'b0, got, lat);
    n_cmp++; if (lat < 0 || ch_val(got, 0) !== 400) begin n_err++; $display("FAIL mid_pre: got %0d expected 400", ch_val(got, 0)); end
    start_frame(600, 600, 1'b0, ok);
    for (int i = 0; i < 11; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL mid_out_data: got %h expected 0", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b expected 0", busy); end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mid_no_out_valid: got %0d pulses expected 0", seen); end
    run_frame(500, -500, 1'b0, got, lat);
    n_cmp++; if (lat !== 36) begin n_err++; $display("FAIL mid_next_latency: got %0d expected 36", lat); end
    n_cmp++; if (ch_val(got, 0) !== 500 || ch_val(got, 1) !== -500) begin n_err++; $display("FAIL mid_next_data: got %0d/%0d expected 500/-500", ch_val(got, 0), ch_val(got, 1)); end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    logic [31:0] data[$];
    do_reset();
    in_data = {16'(-1234), 16'(4321)};
    bypass = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (out_valid) begin pulses.push_back(i); data.push_back(out_data); end
    end
    in_valid = 1'b0;
    n_cmp++; if (pulses.size() !== 4) begin n_err++; $display("FAIL b2b_count: got %0d expected 4", pulses.size()); end
    if (pulses.size() > 0) begin
      n_cmp++; if (pulses[0] !== 35) begin n_err++; $display("FAIL b2b_first: got %0d expected 35", pulses[0]); end
    end
    for (int i = 1; i < pulses.size(); i++) begin
      n_cmp++; if (pulses[i] - pulses[i-1] !== 37) begin n_err++; $display("FAIL b2b_gap[%0d]: got %0d expected 37", i, pulses[i] - pulses[i-1]); end
    end
    for (int i = 0; i < data.size(); i++) begin
      n_cmp++; if (ch_val(data[i], 0) !== 4321 || ch_val(data[i], 1) !== -1234) begin n_err++; $display("FAIL b2b_data[%0d]: got %0d/%0d expected 4321/-1234", i, ch_val(data[i], 0), ch_val(data[i], 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_impulse();
    test_round_sat();
    test_random();
    test_bypass();
    test_coef_gating();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
